// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: edge-captured pending bits, mask, raw view and priority vector.
// Latency: one cycle from request to ACK_O/ERR_O; irq_o lags pending/mask by one cycle.
// Backpressure: none, every accepted request is answered on the next edge.
module wb_irq_ctrl #(
    parameter int          NUM_SRC  = 8,
    parameter logic [29:0] BASE_ADR = 30'h3FFFFFF0
) (
    input  logic               CLK_I,
    input  logic               RST_NI,
    input  logic [29:0]        ADR_I,
    input  logic [31:0]        DAT_I,
    input  logic               CYC_I,
    input  logic               STB_I,
    input  logic               WE_I,
    output logic [31:0]        DAT_O,
    output logic               ACK_O,
    output logic               ERR_O,
    input  logic [NUM_SRC-1:0] irq_i,
    output logic               irq_o
);

    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic               armed;
    logic [29:0]        off;
    logic               hit;
    logic               req;
    logic               wr;
    logic [2:0]         vec_idx;
    logic [31:0]        rdata;
    logic               unused_dat;

    // Subtraction keeps the decode correct for any BASE_ADR alignment.
    assign off        = ADR_I - BASE_ADR;
    assign hit        = (off < 30'd4);
    assign req        = CYC_I & STB_I & ~ACK_O & ~ERR_O;
    assign wr         = req & hit & WE_I;
    assign unused_dat = ^DAT_I;

    // Lines already high when reset releases must not look like fresh edges.
    assign rise   = armed ? (irq_i & ~irq_q) : '0;
    assign clr    = (wr && off[1:0] == 2'd0) ? DAT_I[NUM_SRC-1:0] : '0;
    assign active = pending & mask;

    always_comb begin
        vec_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) vec_idx = 3'(i);
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (off[1:0])
            2'd0:    rdata = 32'(pending);
            2'd1:    rdata = 32'(mask);
            2'd2:    rdata = 32'(irq_i);
            default: rdata = {|active, 28'd0, vec_idx};
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            irq_q   <= '0;
            armed   <= 1'b0;
            pending <= '0;
            mask    <= '0;
            irq_o   <= 1'b0;
            ACK_O   <= 1'b0;
            ERR_O   <= 1'b0;
            DAT_O   <= 32'd0;
        end else begin
            irq_q   <= irq_i;
            armed   <= 1'b1;
            // A new edge wins over a simultaneous clear of the same bit.
            pending <= (pending & ~clr) | rise;
            if (wr && off[1:0] == 2'd1) mask <= DAT_I[NUM_SRC-1:0];
            irq_o   <= |active;
            ACK_O   <= req & hit;
            ERR_O   <= req & ~hit;
            DAT_O   <= (req && hit && !WE_I) ? rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Bench for wb_irq_ctrl: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_wb_irq_ctrl;

    localparam logic [29:0] BASE = 30'h3FFFFFF0;

    logic        CLK_I  = 1'b0;
    logic        RST_NI = 1'b0;
    logic [29:0] ADR_I  = '0;
    logic [31:0] DAT_I  = '0;
    logic        CYC_I  = 1'b0;
    logic        STB_I  = 1'b0;
    logic        WE_I   = 1'b0;
    logic [31:0] DAT_O;
    logic        ACK_O;
    logic        ERR_O;
    logic [7:0]  irq_i  = '0;
    logic        irq_o;

    wb_irq_ctrl #(.NUM_SRC(8), .BASE_ADR(BASE)) dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI), .ADR_I(ADR_I), .DAT_I(DAT_I),
        .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .DAT_O(DAT_O),
        .ACK_O(ACK_O), .ERR_O(ERR_O), .irq_i(irq_i), .irq_o(irq_o)
    );

    always #5 CLK_I = ~CLK_I;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    // Reference state: what software would see, updated once per clock.
    logic [7:0]  m_pend = '0, m_mask = '0, m_prev = '0;
    bit          m_armed = 1'b0;
    logic        m_irq_o = 1'b0, m_ack = 1'b0, m_err = 1'b0;
    logic [31:0] m_dat = '0;
    bit          m_wack = 1'b0;
    logic [7:0]  cur_irq = '0;
    logic [31:0] d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vec_of(input logic [7:0] a);
        for (int i = 0; i < 8; i++) if (a[i]) return 32'h80000000 | i;
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_armed = 1'b0;
        m_irq_o = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_dat = '0; m_wack = 1'b0;
    endtask

    task automatic step(input logic [7:0] irq, input logic cyc, input logic stb, input logic we,
                        input logic [29:0] adr, input logic [31:0] dat);
        logic        acc, hit;
        logic [29:0] off;
        logic [7:0]  np, nm;
        logic [31:0] rd;
        @(negedge CLK_I);
        irq_i = irq; CYC_I = cyc; STB_I = stb; WE_I = we; ADR_I = adr; DAT_I = dat;
        off = adr - BASE;
        hit = (off < 30'd4);
        acc = cyc && stb && !m_ack && !m_err;
        np  = m_pend;
        nm  = m_mask;
        if (acc && hit && we && off == 30'd0) np = np & ~dat[7:0];
        if (acc && hit && we && off == 30'd1) nm = dat[7:0];
        if (m_armed) np = np | (irq & ~m_prev);
        case (off[1:0])
            2'd0:    rd = {24'd0, m_pend};
            2'd1:    rd = {24'd0, m_mask};
            2'd2:    rd = {24'd0, irq};
            default: rd = vec_of(m_pend & m_mask);
        endcase
        @(posedge CLK_I);
        #1;
        m_irq_o = |(m_pend & m_mask);
        m_ack   = acc && hit;
        m_err   = acc && !hit;
        m_wack  = acc && hit && we;
        m_dat   = (acc && hit && !we) ? rd : 32'd0;
        m_pend  = np;
        m_mask  = nm;
        m_prev  = irq;
        m_armed = 1'b1;
        chk("ack", {31'd0, ACK_O}, {31'd0, m_ack});
        chk("err", {31'd0, ERR_O}, {31'd0, m_err});
        chk("irq_o", {31'd0, irq_o}, {31'd0, m_irq_o});
        if (!m_wack) chk("dat_o", DAT_O, m_dat);
    endtask

    task automatic idle();
        step(cur_irq, 1'b0, 1'b0, 1'b0, BASE, 32'd0);
    endtask

    task automatic wr(input logic [1:0] o, input logic [31:0] v);
        step(cur_irq, 1'b1, 1'b1, 1'b1, BASE + 30'(o), v);
        chk("wr_ack", {31'd0, ACK_O}, 32'd1);
        idle();
    endtask

    task automatic rd(input logic [1:0] o, output logic [31:0] v);
        step(cur_irq, 1'b1, 1'b1, 1'b0, BASE + 30'(o), 32'd0);
        v = DAT_O;
        chk("rd_ack", {31'd0, ACK_O}, 32'd1);
        idle();
    endtask

    task automatic setirq(input logic [7:0] v);
        cur_irq = v;
        idle();
    endtask

    // Release between edges so the model's next step covers the first post-reset clock.
    task automatic release_reset();
        @(posedge CLK_I);
        #2;
        CYC_I = 1'b0; STB_I = 1'b0; irq_i = cur_irq;
        RST_NI = 1'b1;
    endtask

    initial begin
        #12;
        chk("rst_irq_o", {31'd0, irq_o}, 32'd0);
        chk("rst_ack", {31'd0, ACK_O}, 32'd0);
        chk("rst_err", {31'd0, ERR_O}, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        model_reset();
        release_reset();
        idle();

        // Edge capture with source 0 unmasked.
        wr(2'd1, 32'h01);
        setirq(8'h01);
        chk("e_irq_o_lag", {31'd0, irq_o}, 32'd0);
        setirq(8'h00);
        chk("e_irq_o", {31'd0, irq_o}, 32'd1);
        rd(2'd0, d); chk("e_pend", d, 32'h01);
        rd(2'd3, d); chk("e_vec", d, 32'h80000000);
        wr(2'd0, 32'h01);
        wr(2'd1, 32'h00);

        // Masked source, then unmask.
        setirq(8'h08);
        setirq(8'h00);
        idle();
        chk("m_irq_o0", {31'd0, irq_o}, 32'd0);
        rd(2'd0, d); chk("m_pend", d, 32'h08);
        wr(2'd1, 32'h08);
        chk("m_irq_o1", {31'd0, irq_o}, 32'd1);
        wr(2'd0, 32'h08);

        // Clear and priority.
        setirq(8'h0A);
        setirq(8'h00);
        wr(2'd1, 32'hFF);
        rd(2'd3, d); chk("p_vec1", d, 32'h80000001);
        wr(2'd0, 32'h02);
        rd(2'd0, d); chk("p_pend", d, 32'h08);
        rd(2'd3, d); chk("p_vec3", d, 32'h80000003);
        wr(2'd0, 32'h08);
        chk("p_irq_o0", {31'd0, irq_o}, 32'd0);
        rd(2'd3, d); chk("p_vec0", d, 32'h0);

        // Clear collides with a new edge on the same bit.
        setirq(8'h04);
        setirq(8'h00);
        step(8'h04, 1'b1, 1'b1, 1'b1, BASE, 32'h04);
        cur_irq = 8'h04;
        idle();
        rd(2'd0, d); chk("c_pend", d, 32'h04);
        rd(2'd2, d); chk("c_raw", d, 32'h04);
        setirq(8'h00);
        wr(2'd0, 32'hFFFFFFFF);
        rd(2'd0, d); chk("c_pend0", d, 32'h0);

        // Unmapped address and back-to-back protection.
        step(cur_irq, 1'b1, 1'b1, 1'b0, BASE + 30'd4, 32'd0);
        chk("b_err", {31'd0, ERR_O}, 32'd1);
        chk("b_ack", {31'd0, ACK_O}, 32'd0);
        chk("b_dat", DAT_O, 32'd0);
        idle();
        step(cur_irq, 1'b1, 1'b1, 1'b1, BASE + 30'd5, 32'h00);
        chk("b_werr", {31'd0, ERR_O}, 32'd1);
        idle();
        rd(2'd1, d); chk("b_mask", d, 32'hFF);
        for (int k = 0; k < 4; k++) begin
            step(cur_irq, 1'b1, 1'b1, 1'b0, BASE + 30'd1, 32'd0);
            chk("b2b_ack", {31'd0, ACK_O}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        idle();

        // Asynchronous reset with everything pending and a read in flight.
        setirq(8'hFF);
        idle();
        chk("r_irq_o1", {31'd0, irq_o}, 32'd1);
        rd(2'd0, d); chk("r_pend", d, 32'hFF);
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = BASE;
        #2;
        RST_NI = 1'b0;
        #1;
        chk("r_irq_o0", {31'd0, irq_o}, 32'd0);
        chk("r_ack0", {31'd0, ACK_O}, 32'd0);
        chk("r_dat0", DAT_O, 32'd0);
        model_reset();
        repeat (2) @(posedge CLK_I);
        release_reset();
        idle();
        chk("r_noack", {31'd0, ACK_O}, 32'd0);
        rd(2'd0, d); chk("r_pend0", d, 32'h0);
        rd(2'd1, d); chk("r_mask0", d, 32'h0);
        chk("r_irq_o", {31'd0, irq_o}, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [29:0] a;
            if ($urandom_range(0, 3) == 0) cur_irq = 8'($urandom);
            a = ($urandom_range(0, 9) == 0) ? BASE - 30'd1 : BASE + 30'($urandom_range(0, 5));
            step(cur_irq, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/wb_irq_ctrl.md
WB_IRQ_CTRL -- requirements
Module: wb_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (legal 1..8).
REQ-002 SHALL have parameter BASE_ADR, default 30'h3FFFFFF0, word address of register 0; registers occupy BASE_ADR..BASE_ADR+3.
REQ-003 SHALL have port CLK_I  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port RST_NI  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ADR_I  input  30  Wishbone word address (byte address bits 31:2).
REQ-006 SHALL have port DAT_I  input  32  Wishbone write data.
REQ-007 SHALL have ports CYC_I, STB_I, WE_I  input  1 each  Wishbone classic cycle, strobe and write-enable.
REQ-008 SHALL have port DAT_O  output  32  Wishbone read data.
REQ-009 SHALL have port ACK_O  output  1  transfer acknowledge.
REQ-010 SHALL have port ERR_O  output  1  error for unmapped address.
REQ-011 SHALL have port irq_i  input  NUM_SRC  interrupt request lines, synchronous to CLK_I, from timer and peer blocks.
REQ-012 SHALL have port irq_o  output  1  combined interrupt to CPU.

Function
REQ-013 SHALL register irq_i each cycle into irq_q; rising edge of source n is irq_i[n] & ~irq_q[n].
REQ-014 SHALL set pending[n] in the cycle after a rising edge is detected on irq_i[n].
REQ-015 SHALL hold pending[n] at 1 until cleared by software; a level held high does not re-set a pending bit after it is cleared.
REQ-016 SHALL drive irq_o, registered, as OR of (pending & mask); irq_o follows a pending or mask change by one cycle.
REQ-017 SHALL accept a request when CYC_I & STB_I & ~ACK_O & ~ERR_O; response is a one-cycle pulse of ACK_O or ERR_O in the following cycle; no back-to-back pulses.
REQ-018 SHALL use register map, offset from BASE_ADR: 0 PENDING (R, write-1-to-clear), 1 MASK (R/W), 2 RAW (R, current irq_i), 3 VECTOR (R).
REQ-019 SHALL read VECTOR as bit 31 = 1 when any (pending & mask) bit is set, bits 2:0 = lowest-numbered such source index, all other bits 0; VECTOR = 0 when none.
REQ-020 SHALL read unused upper bits of PENDING, MASK and RAW (bits 31:NUM_SRC) as 0; writes to them are ignored.
REQ-021 SHALL treat writes to RAW and VECTOR as ACKed no-ops.
REQ-022 SHALL assert ERR_O, not ACK_O, for any address outside BASE_ADR..BASE_ADR+3, with no state change and DAT_O = 0.
REQ-023 SHALL register DAT_O together with ACK_O; DAT_O is 0 when ACK_O is low.
REQ-024 SHALL apply register writes in the same edge that raises ACK_O.
REQ-025 SHALL let a new edge win over a simultaneous write-1-to-clear of the same bit, leaving pending set.
REQ-026 SHALL abort a request with no side effects and no response when CYC_I or STB_I drops before the response edge.

Reset
REQ-027 SHALL, while RST_NI is low, immediately force pending, mask, irq_q, irq_o, ACK_O, ERR_O and DAT_O to 0.
REQ-028 SHALL treat irq_i lines already high when RST_NI deasserts as not having a rising edge (irq_q loads irq_i on the first clock after reset).
REQ-029 SHALL discard any in-flight Wishbone request when reset asserts mid-transfer; no ACK_O follows reset release for it.

Verification
REQ-030 Edge capture: MASK=0x01, pulse irq_i[0] one cycle -> PENDING=0x01 next cycle, irq_o=1 one cycle later, VECTOR=0x80000000.
REQ-031 Masking: MASK=0x00, rising edge on irq_i[3] -> PENDING=0x08, irq_o stays 0; write MASK=0x08 -> irq_o=1 one cycle after ACK_O.
REQ-032 Clear and priority: PENDING=0x0A, MASK=0xFF -> VECTOR=0x80000001; write PENDING=0x02 -> PENDING=0x08, VECTOR=0x80000003; write 0x08 -> irq_o=0 one cycle later.
REQ-033 Collision: write-1-to-clear of bit 2 on the same edge as a new irq_i[2] rising edge -> PENDING bit 2 remains 1.
REQ-034 Bus errors: read at BASE_ADR+4 -> ERR_O pulse one cycle, ACK_O=0, DAT_O=0, registers unchanged; ACK_O never high two consecutive cycles with STB_I held.
REQ-035 Reset mid-operation: PENDING=0xFF, irq_o=1, drop RST_NI asynchronously -> irq_o=0 and all registers 0 before next clock; irq_i held high across release -> PENDING stays 0.
